// File: rtl/vga_pkg.sv
// Shared constants and types for the pixel-plot path into the framebuffer.
package vga_pkg;

    localparam int unsigned H_RES_DEF      = 160;
    localparam int unsigned V_RES_DEF      = 120;
    localparam int unsigned COLOUR_BITS    = 3;
    localparam int unsigned ADDR_W         = 15;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [COLOUR_BITS-1:0] colour;
    } plot_entry_t;

    localparam int unsigned ENTRY_W = $bits(plot_entry_t);

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO with flush; head_next_c is the head as it will be
// after this cycle's push/pop, so the caller can register it without a bubble.
module plot_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_next_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_adv;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_adv  = do_pop ? rd_ptr + PW'(1) : rd_ptr;

    // Write-through when the FIFO would otherwise be empty after the pop.
    assign head_next_c = ((count - CW'(do_pop)) == '0) ? wdata : mem[rd_adv];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/plot_receiver.sv
// Pixel-plot sink: address compute, plot FIFO and framebuffer write engine.
// Full-screen clear engine is built only when PLOT_CLEAR_EN is defined.
module plot_receiver
    import vga_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8:0]             iX,
    input  logic [7:0]             iY,
    input  logic [COLOUR_BITS-1:0] iColour,
    input  logic                   iPlot,
    output logic                   oReady,
    input  logic                   iClear,
    input  logic [COLOUR_BITS-1:0] iClearColour,
    output logic [ADDR_W-1:0]      oMemAddr,
    output logic [COLOUR_BITS-1:0] oMemData,
    output logic                   oMemWe,
    input  logic                   iMemReady,
    output logic                   oBusy,
    output logic [7:0]             oDropCount
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t                 state, state_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [COLOUR_BITS-1:0] data_d;
    logic                   we_d;
    logic                   in_range, accept, push, pop, handshake, flush;
    logic [ADDR_W-1:0]      plot_addr;
    plot_entry_t            push_entry, head_next;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count, fifo_left;

    assign in_range   = (32'(iX) < H_RES) && (32'(iY) < V_RES);
    assign plot_addr  = ADDR_W'(iY) * ADDR_W'(H_RES) + ADDR_W'(iX);
    assign push_entry = '{addr: plot_addr, colour: iColour};
    assign accept     = iPlot & oReady;
    assign push       = accept & in_range;
    assign handshake  = oMemWe & iMemReady;
    assign pop        = (state == WRITE) & handshake;
    assign fifo_left  = fifo_count - CW'(pop) + CW'(push);

`ifdef PLOT_CLEAR_EN
    logic                   clear_req, clr_pend, pend_d;
    logic [COLOUR_BITS-1:0] clr_colour, colour_d;

    assign clear_req = iClear;
    assign oReady    = ~fifo_full & (state != CLEAR) & ~clr_pend;
    assign oBusy     = (fifo_count != '0) | (state == CLEAR) | clr_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_pend   <= 1'b0;
            clr_colour <= '0;
        end else begin
            clr_pend   <= pend_d;
            clr_colour <= colour_d;
        end
    end
`else
    logic unused_clear;

    assign unused_clear = ^{iClear, iClearColour};
    assign oReady       = ~fifo_full;
    assign oBusy        = (fifo_count != '0);
`endif

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .wdata       (push_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .head_next_c (head_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            oMemAddr <= '0;
            oMemData <= '0;
            oMemWe   <= 1'b0;
        end else begin
            state    <= state_d;
            oMemAddr <= addr_d;
            oMemData <= data_d;
            oMemWe   <= we_d;
        end
    end

    // Next state and next write-port contents; the port always shows the FIFO head in WRITE.
    always_comb begin
        state_d = state;
        addr_d  = oMemAddr;
        data_d  = oMemData;
        we_d    = oMemWe;
        flush   = 1'b0;
`ifdef PLOT_CLEAR_EN
        pend_d   = clr_pend;
        colour_d = clear_req ? iClearColour : clr_colour;
`endif
        case (state)
            IDLE: begin
                we_d = 1'b0;
`ifdef PLOT_CLEAR_EN
                if (clear_req) begin
                    state_d = CLEAR;
                    flush   = 1'b1;
                    addr_d  = '0;
                    data_d  = iClearColour;
                    we_d    = 1'b1;
                end else
`endif
                if (push || !fifo_empty) begin
                    state_d = WRITE;
                    addr_d  = head_next.addr;
                    data_d  = head_next.colour;
                    we_d    = 1'b1;
                end
            end
            WRITE: begin
                if (handshake) begin
`ifdef PLOT_CLEAR_EN
                    if (clr_pend || clear_req) begin
                        state_d = CLEAR;
                        flush   = 1'b1;
                        addr_d  = '0;
                        data_d  = colour_d;
                        pend_d  = 1'b0;
                    end else
`endif
                    if (fifo_left == '0) begin
                        state_d = IDLE;
                        we_d    = 1'b0;
                    end else begin
                        addr_d = head_next.addr;
                        data_d = head_next.colour;
                    end
                end
`ifdef PLOT_CLEAR_EN
                else if (clear_req) begin
                    pend_d = 1'b1;
                end
`endif
            end
`ifdef PLOT_CLEAR_EN
            CLEAR: begin
                flush = 1'b1;
                we_d  = 1'b1;
                if (clear_req) begin
                    addr_d = '0;
                    data_d = iClearColour;
                end else if (handshake) begin
                    if (oMemAddr == LAST_ADDR) begin
                        state_d = IDLE;
                        we_d    = 1'b0;
                        addr_d  = '0;
                    end else begin
                        addr_d = oMemAddr + ADDR_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // Saturating count of accepted beats with out-of-range coordinates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oDropCount <= '0;
        end else if (accept && !in_range && oDropCount != 8'd255) begin
            oDropCount <= oDropCount + 8'd1;
        end
    end

endmodule

// File: doc/plot_receiver.md
Name: plot_receiver

Overview:
- Sink end of the pixel-plot interface: consumes the stream of (x, y, colour, plot) beats that the image/MIF readers emit toward the display.
- Converts each beat to a linear framebuffer address and buffers it in a small FIFO.
- Drains writes to a single-port framebuffer memory port under a ready/valid handshake.
- Provides a full-screen clear engine and drops out-of-range coordinates.

Parameters:
- H_RES, 160, horizontal pixels; x valid range 0..H_RES-1.
- V_RES, 120, vertical lines; y valid range 0..V_RES-1.
- COLOUR_BITS, 3, colour width in bits (1 bit per channel).
- FIFO_DEPTH, 4, plot buffer entries; must be a power of two, at least 2.
- ADDR_W, 15, framebuffer address width; H_RES*V_RES must be at most 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- iX  in  9  plot x coordinate.
- iY  in  8  plot y coordinate.
- iColour  in  COLOUR_BITS  plot colour.
- iPlot  in  1  plot valid; a beat is accepted when iPlot and oReady are both high.
- oReady  out  1  receiver can accept a plot this cycle.
- iClear  in  1  single-cycle clear request.
- iClearColour  in  COLOUR_BITS  fill colour, sampled in the cycle iClear is seen.
- oMemAddr  out  ADDR_W  framebuffer write address.
- oMemData  out  COLOUR_BITS  framebuffer write data.
- oMemWe  out  1  write valid.
- iMemReady  in  1  memory accepts the write when oMemWe and iMemReady are both high.
- oBusy  out  1  high when the FIFO is non-empty or a clear is in progress.
- oDropCount  out  8  count of out-of-range plots; saturates at 255.

Behaviour:
- Reset, asynchronous and active-low, forces:
  - state IDLE, FIFO empty, all FIFO pointers 0;
  - oMemWe=0, oMemAddr=0, oMemData=0;
  - oReady=1 (after release), oBusy=0, oDropCount=0.
- Accept and enqueue:
  - On an accepted beat with iX<H_RES and iY<V_RES, enqueue {iY*H_RES+iX, iColour} in the same cycle.
  - Compute the address at full ADDR_W width with no truncation.
  - On an accepted beat with an out-of-range coordinate: do not enqueue; increment oDropCount unless it is already 255.
- oReady = FIFO not full AND state != CLEAR AND no clear pending.
- FIFO:
  - A simultaneous enqueue and dequeue while full is not possible, because oReady is low when full.
  - A simultaneous enqueue and dequeue at any other occupancy keeps the count unchanged.
- States:
  - IDLE: oMemWe=0.
    - FIFO non-empty -> WRITE.
    - Clear latched -> CLEAR.
  - WRITE: oMemAddr and oMemData hold the FIFO head, oMemWe=1. Both are held stable until iMemReady.
    - On a handshake, dequeue. If the FIFO becomes empty -> IDLE; otherwise present the next entry in the next cycle.
    - A clear seen during WRITE is latched as pending. At the next handshake, the FIFO is flushed -> CLEAR.
  - CLEAR:
    - On entry, the FIFO is flushed (plots queued before a clear are discarded).
    - Address counter starts at 0; oMemData = latched clear colour; oMemWe=1.
    - Counter advances on each handshake.
    - After the handshake at address H_RES*V_RES-1 -> IDLE.
    - The counter wraps to 0 at the end and is never presented beyond the last address.
- Clear edge cases:
  - iClear in IDLE -> CLEAR in the next cycle; the first write beat is at address 0 in that cycle.
  - iClear during CLEAR restarts the counter at 0 with the new colour.
  - iClear in the same cycle as an accepted plot: the plot is enqueued, then discarded by the flush.
- oBusy = (FIFO count != 0) OR (state == CLEAR) OR clear pending.
- Latency: from plot acceptance into an empty FIFO in IDLE to oMemWe=1 with that address is 1 cycle.
- Reset asserted mid-operation (WRITE or CLEAR) aborts it immediately; oMemWe drops asynchronously.

Optional Feature:
- PLOT_CLEAR_EN defined:
  - The clear engine, CLEAR state, iClear and iClearColour are functional as described.
- PLOT_CLEAR_EN undefined:
  - iClear and iClearColour are ignored.
  - The state machine has only IDLE and WRITE.
  - oReady = FIFO not full.
  - The ports remain present so instantiations do not change.

Decomposition:
- Shared package vga_pkg:
  - H_RES and V_RES defaults, COLOUR_BITS, ADDR_W;
  - the state enum {IDLE, WRITE, CLEAR};
  - the FIFO entry typedef {addr, colour}.
- One sub-module: plot_fifo, a synchronous FIFO parameterised on depth and entry width.
  - Ports: push, pop, full, empty, count, flush.
  - Asynchronous active-low reset.
- The FSM, address compute and drop counter live in plot_receiver.

Test Plan:
1. After reset, plot (x=5, y=2, colour=3'b101) with iMemReady=1 -> next cycle oMemWe=1, oMemAddr=325, oMemData=5; oBusy drops after the handshake.
2. iMemReady held 0 and 5 consecutive plots offered -> oReady falls after 4 accepted; oMemAddr/oMemData stay stable; releasing iMemReady drains 4 writes in order.
3. Plots at (160,0), (0,120), then (159,119) -> oDropCount=2; exactly one write occurs, at address 19199.
4. iClear with iClearColour=3'b010, iMemReady=1 -> 19200 consecutive writes at addresses 0..19199, data 2; oReady low throughout; then IDLE with oBusy=0.
5. Three plots queued with iMemReady=0, then iClear -> FIFO head completes at its handshake, the remaining 2 entries are discarded, and the clear starts at address 0.
6. Reset asserted midway through a clear (address ~100) -> oMemWe=0 immediately and oDropCount=0; after release, a plot at (0,0) writes address 0.
